// File: rtl/merger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : merger_pkg
// Description : Shared types and helpers for the SpGEMM merger datapath.
//               Holds the merge-node payload record and the source-tag width
//               helper used by every merger generation.
// Revision    : 1.0 - initial release
// ============================================================================
package merger_pkg;

  // Width of a source-lane tag for a given lane count (never below one bit).
  function automatic int src_width(input int num_inputs);
    return (num_inputs > 1) ? $clog2(num_inputs) : 1;
  endfunction

  localparam int DEFAULT_INPUTS  = 64;
  localparam int DEFAULT_COORD_W = 64;
  localparam int DEFAULT_SRC_W   = src_width(DEFAULT_INPUTS);

  // Contents of one merge-node output register at the default geometry.
  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_COORD_W-1:0] coord;
    logic [DEFAULT_SRC_W-1:0] src;
    logic                     done;
  } node_payload_t;

endpackage
`default_nettype wire

// File: rtl/merge_node2.sv
`default_nettype none
// ============================================================================
// Module      : merge_node2
// Description : Two-input registered merge node. Picks the smaller head of
//               two sorted child streams (ties to child a), stalls while
//               either child is undecided, and prepends its select bit to the
//               child's source tag.
// Revision    : 1.0 - initial release
// ============================================================================
module merge_node2 #(
  parameter int COORD_W = 64,
  parameter int TAG_W   = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               a_valid,
  input  logic [COORD_W-1:0] a_coord,
  input  logic [TAG_W-1:0]   a_src,
  input  logic               a_done,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [COORD_W-1:0] b_coord,
  input  logic [TAG_W-1:0]   b_src,
  input  logic               b_done,
  output logic               b_ready,
  input  logic               parent_ready,
  output logic               node_valid,
  output logic [COORD_W-1:0] node_coord,
  output logic [TAG_W-1:0]   node_src,
  output logic               node_done
);

  logic               r_valid;
  logic [COORD_W-1:0] r_coord;
  logic [TAG_W-1:0]   r_src;
  logic               r_done;

  logic               w_take_a;
  logic               w_take_b;
  logic               w_load;
  logic [COORD_W-1:0] w_sel_coord;
  logic [TAG_W-1:0]   w_sel_tag;

  // Selection: a child wins only when the other is known to be larger or
  // exhausted; an undecided child blocks the node to keep global order.
  // Child tags arrive zero-extended, so the top bit is free for our select.
  always_comb begin
    w_take_a    = a_valid && (b_done || (b_valid && (a_coord <= b_coord)));
    w_take_b    = b_valid && (a_done || (a_valid && (b_coord < a_coord)));
    w_load      = !r_valid || parent_ready;
    w_sel_coord = w_take_b ? b_coord : a_coord;
    w_sel_tag   = w_take_b ? b_src : a_src;
    w_sel_tag[TAG_W-1] = w_take_b;
  end

  assign a_ready    = w_load && w_take_a;
  assign b_ready    = w_load && w_take_b;
  assign node_valid = r_valid;
  assign node_coord = r_coord;
  assign node_src   = r_src;
  assign node_done  = r_done;

  // Output register: load the winner, drain when the parent consumes, and
  // flag done once both children are exhausted and nothing is held here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_coord <= '0;
      r_src   <= '0;
      r_done  <= 1'b0;
    end else begin
      if (w_load && (w_take_a || w_take_b)) begin
        r_valid <= 1'b1;
        r_coord <= w_sel_coord;
        r_src   <= w_sel_tag;
      end else if (parent_ready) begin
        r_valid <= 1'b0;
      end
      r_done <= a_done && b_done && !r_valid;
    end
  end

endmodule
`default_nettype wire

// File: rtl/merge_tree_n.sv
`default_nettype none
// ============================================================================
// Module      : merge_tree_n
// Description : N-way streaming merger. A binary tree of registered
//               merge_node2 instances merges NUM_INPUTS sorted coordinate
//               streams into one ascending stream tagged with its lane.
// Revision    : 1.0 - initial release
// ============================================================================
module merge_tree_n
  import merger_pkg::*;
#(
  parameter int NUM_INPUTS = 64,
  parameter int COORD_W    = 64,
  parameter int SRC_W      = src_width(NUM_INPUTS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_INPUTS*COORD_W-1:0] in_coord,
  input  logic [NUM_INPUTS-1:0]         in_valid,
  input  logic [NUM_INPUTS-1:0]         in_done,
  output logic [NUM_INPUTS-1:0]         in_ready,
  output logic [COORD_W-1:0]            out_coord,
  output logic [SRC_W-1:0]              out_src,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_done
);

  localparam int LEVELS = $clog2(NUM_INPUTS);
  localparam int NODES  = NUM_INPUTS - 1;

  // Nodes are stored level by level: level l starts at NUM_INPUTS - (NUM_INPUTS >> l);
  // the root is the last entry.
  logic               w_node_valid   [NODES];
  logic [COORD_W-1:0] w_node_coord   [NODES];
  logic [SRC_W-1:0]   w_node_src     [NODES];
  logic               w_node_done    [NODES];
  logic               w_a_ready      [NODES];
  logic               w_b_ready      [NODES];
  logic               w_parent_ready [NODES];
  logic [NUM_INPUTS-1:0] w_leaf_ready;

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int BASE  = NUM_INPUTS - (NUM_INPUTS >> l);
    localparam int CNT   = NUM_INPUTS >> (l + 1);
    localparam int CBASE = BASE - 2 * CNT;
    localparam int TW    = l + 1;

    for (genvar j = 0; j < CNT; j++) begin : g_node
      localparam int K = BASE + j;

      logic               a_v, b_v, a_d, b_d;
      logic [COORD_W-1:0] a_c, b_c;
      logic [TW-1:0]      a_s, b_s, tag;

      if (l == 0) begin : g_leaf
        assign a_v = in_valid[2*j];
        assign b_v = in_valid[2*j+1];
        assign a_d = in_done[2*j];
        assign b_d = in_done[2*j+1];
        assign a_c = in_coord[(2*j)*COORD_W +: COORD_W];
        assign b_c = in_coord[(2*j+1)*COORD_W +: COORD_W];
        assign a_s = '0;
        assign b_s = '0;
        assign w_leaf_ready[2*j]   = w_a_ready[K];
        assign w_leaf_ready[2*j+1] = w_b_ready[K];
      end else begin : g_inner
        assign a_v = w_node_valid[CBASE+2*j];
        assign b_v = w_node_valid[CBASE+2*j+1];
        assign a_d = w_node_done[CBASE+2*j];
        assign b_d = w_node_done[CBASE+2*j+1];
        assign a_c = w_node_coord[CBASE+2*j];
        assign b_c = w_node_coord[CBASE+2*j+1];
        assign a_s = TW'(w_node_src[CBASE+2*j]);
        assign b_s = TW'(w_node_src[CBASE+2*j+1]);
      end

      if (l == LEVELS - 1) begin : g_root
        assign w_parent_ready[K] = out_ready;
      end else if ((j % 2) == 0) begin : g_left
        assign w_parent_ready[K] = w_a_ready[BASE + CNT + j/2];
      end else begin : g_right
        assign w_parent_ready[K] = w_b_ready[BASE + CNT + j/2];
      end

      merge_node2 #(
        .COORD_W (COORD_W),
        .TAG_W   (TW)
      ) u_node (
        .clock        (clock),
        .reset        (reset),
        .a_valid      (a_v),
        .a_coord      (a_c),
        .a_src        (a_s),
        .a_done       (a_d),
        .a_ready      (w_a_ready[K]),
        .b_valid      (b_v),
        .b_coord      (b_c),
        .b_src        (b_s),
        .b_done       (b_d),
        .b_ready      (w_b_ready[K]),
        .parent_ready (w_parent_ready[K]),
        .node_valid   (w_node_valid[K]),
        .node_coord   (w_node_coord[K]),
        .node_src     (tag),
        .node_done    (w_node_done[K])
      );

      assign w_node_src[K] = SRC_W'(tag);
    end
  end

  assign out_valid = w_node_valid[NODES-1];
  assign out_coord = w_node_coord[NODES-1];
  assign out_src   = w_node_src[NODES-1];
  assign out_done  = w_node_done[NODES-1];

  // No lane may hand off a coordinate while the tree is being cleared.
  assign in_ready  = reset ? '0 : w_leaf_ready;

endmodule
`default_nettype wire

// File: tb/tb_merge_tree_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_merge_tree_n
// Description : Directed self-checking bench for merge_tree_n using a 4-lane
//               and a 64-lane instance with 8-bit coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_merge_tree_n;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  lane_valid = '0;
  logic [63:0]  lane_done  = '0;
  logic [511:0] lane_coord = '0;
  logic         out_ready  = 1'b1;

  logic [3:0]   rdy4;
  logic [7:0]   c4;
  logic [1:0]   s4;
  logic         v4, d4;
  logic [63:0]  rdy64;
  logic [7:0]   c64;
  logic [5:0]   s64;
  logic         v64, d64;

  bit           sel64 = 1'b0;
  logic         obs_valid, obs_done;
  logic [7:0]   obs_coord;
  logic [5:0]   obs_src;
  logic [63:0]  obs_rdy;

  int checks = 0;
  int errors = 0;

  logic [7:0]   lane_q [64][$];
  int           lane_delay [64];
  logic [13:0]  exp_q [$];

  merge_tree_n #(.NUM_INPUTS(4), .COORD_W(8)) dut4 (
    .clock(clk), .reset(rst),
    .in_coord(lane_coord[31:0]), .in_valid(lane_valid[3:0]), .in_done(lane_done[3:0]),
    .in_ready(rdy4), .out_coord(c4), .out_src(s4), .out_valid(v4),
    .out_ready(out_ready), .out_done(d4)
  );

  merge_tree_n #(.NUM_INPUTS(64), .COORD_W(8)) dut64 (
    .clock(clk), .reset(rst),
    .in_coord(lane_coord), .in_valid(lane_valid), .in_done(lane_done),
    .in_ready(rdy64), .out_coord(c64), .out_src(s64), .out_valid(v64),
    .out_ready(out_ready), .out_done(d64)
  );

  always #5 clk = ~clk;

  // Observe whichever instance the current test targets.
  always_comb begin
    obs_valid = sel64 ? v64 : v4;
    obs_done  = sel64 ? d64 : d4;
    obs_coord = sel64 ? c64 : c4;
    obs_src   = sel64 ? s64 : {4'b0, s4};
    obs_rdy   = sel64 ? rdy64 : {60'b0, rdy4};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < 64; i++) begin
      lane_q[i].delete();
      lane_delay[i] = 0;
    end
    exp_q.delete();
    lane_valid = '0;
    lane_done  = '0;
    lane_coord = '0;
  endtask

  task automatic push_exp(input logic [7:0] coord, input logic [5:0] src);
    exp_q.push_back({src, coord});
  endtask

  // Present each lane's head; an empty lane past its delay reports done.
  task automatic drive_lanes(input int cyc);
    for (int i = 0; i < 64; i++) begin
      lane_valid[i] = 1'b0;
      lane_done[i]  = 1'b0;
      lane_coord[i*8 +: 8] = 8'd0;
      if (cyc >= lane_delay[i]) begin
        if (lane_q[i].size() > 0) begin
          lane_valid[i] = 1'b1;
          lane_coord[i*8 +: 8] = lane_q[i][0];
        end else begin
          lane_done[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic do_pops();
    for (int i = 0; i < 64; i++)
      if (lane_valid[i] && obs_rdy[i]) void'(lane_q[i].pop_front());
  endtask

  task automatic start_test(input bit use64);
    rst       = 1'b1;
    out_ready = 1'b1;
    sel64     = use64;
    clear_lanes();
    repeat (2) @(posedge clk);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Run until every expected item is seen and out_done rises, or budget ends.
  task automatic run(input string name, input int max_cyc, input bit toggle, input int quiet);
    int         cyc = 0;
    bit         stalled = 1'b0;
    logic [7:0] held_c = '0;
    logic [5:0] held_s = '0;
    logic [13:0] e;
    while ((exp_q.size() > 0 || !obs_done) && cyc < max_cyc) begin
      @(negedge clk);
      drive_lanes(cyc);
      out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      if (stalled) begin
        check({name, "_hold_valid"}, obs_valid, 1);
        check({name, "_hold_coord"}, obs_coord, held_c);
        check({name, "_hold_src"}, obs_src, held_s);
      end
      if (cyc < quiet) check({name, "_quiet"}, obs_valid, 0);
      if (obs_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({name, "_extra_output"}, obs_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check({name, "_coord"}, obs_coord, e[7:0]);
          check({name, "_src"}, obs_src, e[13:8]);
        end
      end
      stalled = obs_valid && !out_ready;
      held_c  = obs_coord;
      held_s  = obs_src;
      do_pops();
      cyc++;
    end
    check({name, "_missing_outputs"}, exp_q.size(), 0);
    check({name, "_out_done"}, obs_done, 1);
    @(negedge clk);
    #1;
    check({name, "_idle_after_done"}, obs_valid, 0);
  endtask

  initial begin
    // Reset values
    #1;
    check("reset_out_valid", v4, 0);
    check("reset_out_done", d4, 0);
    check("reset_in_ready", rdy4, 0);

    // Basic 4-way merge
    start_test(1'b0);
    lane_q[0] = '{8'd1, 8'd5, 8'd9};
    lane_q[1] = '{8'd2, 8'd6};
    lane_q[2] = '{8'd3};
    lane_q[3] = '{8'd4, 8'd7, 8'd8};
    push_exp(1, 0); push_exp(2, 1); push_exp(3, 2); push_exp(4, 3); push_exp(5, 0);
    push_exp(6, 1); push_exp(7, 3); push_exp(8, 3); push_exp(9, 0);
    check("reset_coord", c4, 0);
    check("reset_src", s4, 0);
    release_rst();
    run("merge4", 100, 1'b0, 0);

    // Equal coordinates: lower lane first
    start_test(1'b0);
    lane_q[0] = '{8'd10};
    lane_q[3] = '{8'd10};
    push_exp(10, 0); push_exp(10, 3);
    release_rst();
    run("tie", 60, 1'b0, 0);

    // Undecided lane must hold back a valid neighbour
    start_test(1'b0);
    lane_q[0] = '{8'd20};
    lane_q[1] = '{8'd15};
    lane_delay[1] = 5;
    push_exp(15, 1); push_exp(20, 0);
    release_rst();
    run("stall", 60, 1'b0, 6);

    // Backpressure on 64 lanes with out_ready toggling
    start_test(1'b1);
    for (int i = 0; i < 64; i++) begin
      lane_q[i].push_back(8'(i));
      push_exp(8'(i), 6'(i));
    end
    release_rst();
    run("bp64", 400, 1'b1, 0);

    // All lanes exhausted at reset release
    start_test(1'b0);
    drive_lanes(0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      check("empty_valid4", v4, 0);
      check("empty_valid64", v64, 0);
      if (e == 1) check("empty_done4_early", d4, 0);
      if (e == 2) check("empty_done4", d4, 1);
      if (e == 5) check("empty_done64_early", d64, 0);
      if (e == 6) check("empty_done64", d64, 1);
    end

    // Reset with three entries in flight
    start_test(1'b0);
    lane_q[0] = '{8'd1};
    lane_q[1] = '{8'd2};
    lane_q[2] = '{8'd3};
    release_rst();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_lanes(c);
      out_ready = 1'b0;
      #1;
      do_pops();
    end
    check("inflight_valid", v4, 1);
    check("inflight_coord", c4, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", v4, 0);
    check("async_rst_coord", c4, 0);
    check("async_rst_ready", rdy4, 0);
    clear_lanes();
    out_ready = 1'b1;
    lane_q[0] = '{8'd7};
    push_exp(7, 0);
    repeat (2) @(posedge clk);
    release_rst();
    run("after_rst", 60, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/merge_tree_n.md
# merge_tree_n

Parametrised N-way streaming merger for the SpGEMM merger datapath, the next generation of the fixed radix-64 quaternary-merger tree. It merges NUM_INPUTS independently sorted coordinate streams into one ascending stream, tagging each output with its source lane. Every lane and the output use valid/ready handshakes. Every tree level is registered, so the block pipelines at one coordinate per cycle. It sits between the per-row fiber fetchers and the multiply/accumulate stage.

## Interface
- NUM_INPUTS, default 64: number of input streams; power of two, at least 2.
- COORD_W, default 64: coordinate width in bits.
- SRC_W, default $clog2(NUM_INPUTS): width of the source-lane tag. Derived; do not override.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  reset is asynchronous and active-high.
- in_coord  in  NUM_INPUTS*COORD_W  lane i occupies bits [i*COORD_W +: COORD_W].
- in_valid  in  NUM_INPUTS  lane i presents a coordinate.
- in_done  in  NUM_INPUTS  lane i is exhausted; level signal held until reset; in_valid is 0 while in_done is 1.
- in_ready  out  NUM_INPUTS  lane i coordinate is accepted this cycle when in_valid is also 1.
- out_coord  out  COORD_W  merged coordinate.
- out_src  out  SRC_W  lane index that out_coord came from.
- out_valid  out  1  out_coord and out_src are valid.
- out_ready  in  1  downstream accepts this cycle.
- out_done  out  1  all lanes are done and the tree is empty; sticky until reset.

## Operation
- The tree is built from log2(NUM_INPUTS) levels of binary merge nodes. Level 0 node j takes lanes 2j and 2j+1. The root drives the outputs.
- Each node holds one output register: valid, coord, src and done. Each node sees two children, a and b, each with valid, coord, src and done.
- Selection rule for a node:
  - Take a if a.valid, and b is either done or valid with a.coord <= b.coord (unsigned).
  - Take b if b.valid, and a is either done or valid with b.coord < a.coord.
  - Ties go to a, the lower lane index. Merging duplicate coordinates is not done here; equal coordinates appear back to back.
- If one child is neither valid nor done, the node stalls, even when the other child is valid. This is required for correct ordering.
- Node load enable is ld = !reg.valid || parent_ready. A node loads the selected child when ld is 1 and a selection exists. Otherwise it clears its valid when parent_ready consumes the current entry.
- Child ready is ld and (this child selected). Ready is combinational top-down: out_ready reaches the leaves within the same cycle.
- A node asserts done when a.done && b.done && !reg.valid. Done is registered, so it adds one cycle per level.
- out_src is built up level by level: the node prepends its select bit above the child's tag. The root tag equals the lane index.
- Reset (asynchronous): all node valid and done bits go to 0, out_valid=0, out_done=0, out_coord=0, out_src=0. in_ready is forced to 0 while reset is high. A reset mid-stream discards all in-flight entries. No output follows reset deassertion until new input arrives.

## Timing
- Latency from a lane accept to out_valid is log2(NUM_INPUTS) cycles on an empty, unstalled tree. This is 6 cycles for 64 lanes.
- Sustained throughput is 1 coordinate/cycle when out_ready=1 and the selected lane stays valid.
- Backpressure: when out_ready=0 and the root is valid, the root holds its values stable. in_ready drops only once the full path is occupied.
- out_done rises log2(NUM_INPUTS) cycles after the last in_done once every node is empty.
- A lane with in_done=1 from reset never blocks the tree. If all lanes are done at reset release, out_done=1 after log2(NUM_INPUTS) cycles with no out_valid.

## Structure
- The shared package merger_pkg holds the node payload struct (valid, coord, src, done) and a clog2-based SRC_W helper. Existing mergers reuse it.
- One sub-module, merge_node2, is parametrised by COORD_W and a per-level tag width. The top instantiates it in a generate loop over levels and indices, with flattened per-level wire arrays.

## Test plan
- NUM_INPUTS=4, COORD_W=8. Lanes: {1,5,9}, {2,6}, {3}, {4,7,8}, each followed by in_done, out_ready=1. Output is 1,2,3,4,5,6,7,8,9 with src 0,1,2,3,0,1,3,3,0. out_done follows.
- Tie: lanes 0 and 3 both send 10. Output is 10/src0 then 10/src3.
- Stall ordering: lane 0 is valid with 20, lane 1 is neither valid nor done for 5 cycles, then sends 15. Output is 15 before 20, and nothing is output during the stall.
- Backpressure: 64 lanes each send one coordinate equal to its lane index. out_ready toggles 1/0 every cycle. All 64 emerge in order 0..63 with no loss or duplication, and the data stays stable while stalled.
- Empty: all in_done=1 at reset release. out_valid stays 0 and out_done=1 on cycle log2(N).
- Reset mid-stream: assert reset with 3 entries in flight. out_valid=0 immediately, then fresh stream {7} yields exactly one output, 7.
